// File: rtl/neuron_layer_seq.sv
// Time-multiplexed fully-connected layer: N_OUT sign-magnitude neurons sharing one MAC.
// Optional feature: define NEURON_RELU_EN to clamp negative neuron outputs to zero.
module neuron_layer_seq #(
  parameter int W     = 17,
  parameter int N_IN  = 7,
  parameter int N_OUT = 13,
  parameter int FRAC  = 8,
  parameter int ACC_W = 40
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  input  logic [W*N_IN-1:0]         x,
  input  logic [W*N_IN*N_OUT-1:0]   w,
  output logic                      busy,
  output logic                      done,
  output logic [W*N_OUT-1:0]        y
);

  localparam int IW = (N_IN  > 1) ? $clog2(N_IN)  : 1;
  localparam int JW = (N_OUT > 1) ? $clog2(N_OUT) : 1;
  localparam int PW = 2 * (W - 1);
  localparam logic [ACC_W-1:0] MAG_MAX = (ACC_W'(1) << (W - 1)) - ACC_W'(1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_MAC,
    S_STORE,
    S_DONE
  } state_t;

  state_t state, state_nx;

  logic [W*N_IN-1:0] xr;
  logic [ACC_W-1:0]  acc;
  logic [IW-1:0]     i;
  logic [JW-1:0]     j;

  logic [W-1:0]      xa, wb;
  logic [PW-1:0]     mag_full;
  logic [ACC_W-1:0]  mag_ext;
  logic [ACC_W-1:0]  prod;
  logic [ACC_W-1:0]  abs_acc;
  logic [W-2:0]      sat_mag;
  logic [W-1:0]      y_word;

  // Shared MAC operand selection and signed product.
  always_comb begin
    xa       = xr[W*i +: W];
    wb       = w[W*(j*N_IN+i) +: W];
    mag_full = xa[W-2:0] * wb[W-2:0];
    mag_ext  = '0;
    mag_ext[PW-1:0] = mag_full >> FRAC;
    // A -0 operand yields a zero magnitude, so negating it still gives +0.
    prod     = (xa[W-1] ^ wb[W-1]) ? (ACC_W'(0) - mag_ext) : mag_ext;
  end

  // Symmetric saturation back into sign-magnitude; zero is never emitted as -0.
  always_comb begin
    abs_acc = acc[ACC_W-1] ? (ACC_W'(0) - acc) : acc;
    sat_mag = (abs_acc > MAG_MAX) ? MAG_MAX[W-2:0] : abs_acc[W-2:0];
    y_word  = (sat_mag == '0) ? '0 : {acc[ACC_W-1], sat_mag};
`ifdef NEURON_RELU_EN
    if (acc[ACC_W-1]) y_word = '0;
`endif
  end

  always_comb begin
    state_nx = state;
    busy     = 1'b0;
    done     = 1'b0;
    case (state)
      S_IDLE: begin
        if (start) state_nx = S_MAC;
      end
      S_MAC: begin
        busy = 1'b1;
        if (i == IW'(N_IN - 1)) state_nx = S_STORE;
      end
      S_STORE: begin
        busy = 1'b1;
        state_nx = (j == JW'(N_OUT - 1)) ? S_DONE : S_MAC;
      end
      S_DONE: begin
        done     = 1'b1;
        state_nx = S_IDLE;
      end
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
      xr    <= '0;
      acc   <= '0;
      i     <= '0;
      j     <= '0;
      y     <= '0;
    end else begin
      state <= state_nx;
      case (state)
        S_IDLE: begin
          if (start) begin
            xr  <= x;
            acc <= '0;
            i   <= '0;
            j   <= '0;
          end
        end
        S_MAC: begin
          acc <= acc + prod;
          i   <= i + IW'(1);
        end
        S_STORE: begin
          y[W*j +: W] <= y_word;
          acc <= '0;
          i   <= '0;
          if (j != JW'(N_OUT - 1)) j <= j + JW'(1);
        end
        default: ;
      endcase
    end
  end

endmodule
